// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-256 register driver.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } aes_state_e;

    localparam logic [3:0] NR       = 4'd14;
    localparam logic [3:0] KEY_BASE = 4'd0;
    localparam logic [3:0] PT_BASE  = 4'd8;

    // Round constant for key-schedule word i, indexed by i/8 (valid 1..7).
    function automatic logic [7:0] rcon(input logic [2:0] idx);
        logic [7:0] r;
        case (idx)
            3'd1:    r = 8'h01;
            3'd2:    r = 8'h02;
            3'd3:    r = 8'h04;
            3'd4:    r = 8'h08;
            3'd5:    r = 8'h10;
            3'd6:    r = 8'h20;
            3'd7:    r = 8'h40;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // MixColumns on one column; col[31:24] is row 0.
    function automatic logic [31:0] mixcolumn(input logic [31:0] col);
        logic [7:0] b0, b1, b2, b3;
        logic [7:0] r0, r1, r2, r3;
        b0 = col[31:24];
        b1 = col[23:16];
        b2 = col[15:8];
        b3 = col[7:0];
        r0 = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
        r1 = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
        r2 = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
        r3 = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
        return {r0, r1, r2, r3};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational table lookup.
module aes_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    // Entry n lives at bits [2047-8n -: 8]; row n/16 of the usual table per line.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // 2047 - 8*n == {~n, 3'b111}
    assign byte_o = SBOX[{~byte_i, 3'b111} -: 8];

endmodule

// File: rtl/aes256_reg_driver.sv
// Register-mapped AES-256 encrypt engine: host loads key/PT words, starts,
// polls done_flag and reads the ciphertext back one word at a time.
module aes256_reg_driver
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic [3:0]  write_addr,
    input  logic        write_en,
    input  logic        start_cmd,
    output logic        done_flag,
    output logic [31:0] data_out,
    input  logic [1:0]  read_addr
);

    aes_state_e     state_q, state_d;
    logic [3:0]     round_q, round_d;
    logic [255:0]   key_q, key_d;
    logic [127:0]   pt_q, pt_d;
    logic [127:0]   ct_q, ct_d;
    logic           done_q, done_d;
    logic [127:0]   blk_q, blk_d;   // cipher state
    logic [255:0]   kw_q, kw_d;     // key-schedule window, oldest word at [255:224]

    logic [7:0]     sb [16];
    logic [7:0]     sr [16];
    logic [127:0]   round_out;
    logic [31:0]    sub_w;
    logic [31:0]    temp_w;
    logic [255:0]   kw_next;
    logic           host_ok;
    logic           write_ok;
    logic           start_ok;

    // SubBytes on the 16 state bytes plus SubWord on the newest schedule word.
    for (genvar g = 0; g < 16; g++) begin : g_sub_bytes
        aes_sbox u_sbox (
            .byte_i (blk_q[127-8*g -: 8]),
            .byte_o (sb[g])
        );
    end

    for (genvar g = 0; g < 4; g++) begin : g_sub_word
        aes_sbox u_sbox (
            .byte_i (kw_q[31-8*g -: 8]),
            .byte_o (sub_w[31-8*g -: 8])
        );
    end

    // One cipher round: ShiftRows, MixColumns (skipped on the last round), AddRoundKey.
    always_comb begin
        round_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r+4*c] = sb[r+4*((c+r)%4)];
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (round_q == NR) begin
                round_out[127-32*c -: 32] = {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]}
                                            ^ kw_q[127-32*c -: 32];
            end else begin
                round_out[127-32*c -: 32] =
                    mixcolumn({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]})
                    ^ kw_q[127-32*c -: 32];
            end
        end
    end

    // Next 4-word key block; round r consumes the low half of the window, so the
    // block built after odd rounds starts at a multiple of 8 words (Rot+Sub+Rcon).
    always_comb begin
        if (round_q[0]) begin
            temp_w = {sub_w[23:0], sub_w[31:24]}
                     ^ {rcon(3'((round_q + 4'd1) >> 1)), 24'h000000};
        end else begin
            temp_w = sub_w;
        end
        kw_next[255:128] = kw_q[127:0];
        kw_next[127:96]  = kw_q[255:224] ^ temp_w;
        kw_next[95:64]   = kw_q[223:192] ^ kw_next[127:96];
        kw_next[63:32]   = kw_q[191:160] ^ kw_next[95:64];
        kw_next[31:0]    = kw_q[159:128] ^ kw_next[63:32];
    end

    assign host_ok  = (state_q == IDLE) || (state_q == DONE);
    assign write_ok = write_en && host_ok;
    assign start_ok = start_cmd && !write_en && host_ok;

    // FSM next-state plus register-file and datapath updates.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        key_d   = key_q;
        pt_d    = pt_q;
        ct_d    = ct_q;
        done_d  = done_q;
        blk_d   = blk_q;
        kw_d    = kw_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (write_ok) begin
                    for (int i = 0; i < 8; i++) begin
                        if (write_addr == KEY_BASE + 4'(i)) begin
                            key_d[255-32*i -: 32] = data_in;
                        end
                    end
                    for (int p = 0; p < 4; p++) begin
                        if (write_addr == PT_BASE + 4'(p)) begin
                            pt_d[127-32*p -: 32] = data_in;
                        end
                    end
                end
                if (start_ok) begin
                    done_d  = 1'b0;
                    blk_d   = pt_q;
                    kw_d    = key_q;
                    state_d = INIT;
                end
            end
            INIT: begin
                blk_d   = blk_q ^ kw_q[255:128];
                round_d = 4'd1;
                state_d = ROUND;
            end
            ROUND: begin
                blk_d = round_out;
                kw_d  = kw_next;
                if (round_q == NR) begin
                    ct_d    = round_out;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            key_q   <= '0;
            pt_q    <= '0;
            ct_q    <= '0;
            done_q  <= 1'b0;
            blk_q   <= '0;
            kw_q    <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            key_q   <= key_d;
            pt_q    <= pt_d;
            ct_q    <= ct_d;
            done_q  <= done_d;
            blk_q   <= blk_d;
            kw_q    <= kw_d;
        end
    end

    assign done_flag = done_q;

    // Ciphertext read mux, word 0 is the most significant.
    always_comb begin
        data_out = 32'h0;
        unique case (read_addr)
            2'd0: data_out = ct_q[127:96];
            2'd1: data_out = ct_q[95:64];
            2'd2: data_out = ct_q[63:32];
            2'd3: data_out = ct_q[31:0];
            default: data_out = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_aes256_reg_driver.sv
// Scoreboard bench for aes256_reg_driver using published AES-256 vectors.
module tb_aes256_reg_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic [3:0]  write_addr;
    logic        write_en;
    logic        start_cmd;
    logic        done_flag;
    logic [31:0] data_out;
    logic [1:0]  read_addr;

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] exp_q [$];

    localparam logic [255:0] KEY1 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY2 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] PT2  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT2  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
    localparam logic [127:0] CT0  = 128'hdc95c078a2408989ad48a21492842087;

    aes256_reg_driver dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .write_addr (write_addr),
        .write_en   (write_en),
        .start_cmd  (start_cmd),
        .done_flag  (done_flag),
        .data_out   (data_out),
        .read_addr  (read_addr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        write_en   = 1'b1;
        write_addr = a;
        data_in    = d;
        @(posedge clk);
        #1;
        write_en = 1'b0;
    endtask

    task automatic load_vector(input logic [255:0] key, input logic [127:0] pt);
        for (int k = 0; k < 8; k++) write_word(4'(k), key[255-32*k -: 32]);
        for (int p = 0; p < 4; p++) write_word(4'(8 + p), pt[127-32*p -: 32]);
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start_cmd = 1'b1;
        @(posedge clk);
        #1;
        start_cmd = 1'b0;
    endtask

    task automatic read_ct(output logic [127:0] ct);
        ct = '0;
        for (int r = 0; r < 4; r++) begin
            read_addr = 2'(r);
            #1;
            ct[127-32*r -: 32] = data_out;
        end
    endtask

    // Counts rising edges after the start edge until done_flag, bounded.
    task automatic wait_done(input int c0, output int c);
        c = c0;
        while (!done_flag && c < 40) begin
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    task automatic finish_vec(input string tag, input int cyc);
        logic [127:0] ct;
        logic [127:0] exp;
        check_eq({tag, "_latency"}, 128'(cyc), 128'd15);
        read_ct(ct);
        check_eq({tag, "_sb_nonempty"}, 128'(exp_q.size() != 0), 128'd1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        check_eq({tag, "_ct"}, ct, exp);
    endtask

    task automatic run_vec(input string tag, input logic [255:0] key, input logic [127:0] pt,
                           input logic [127:0] exp_ct);
        int c;
        load_vector(key, pt);
        exp_q.push_back(exp_ct);
        start_pulse();
        check_eq({tag, "_done_drop"}, 128'(done_flag), 128'd0);
        wait_done(0, c);
        finish_vec(tag, c);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ct;
        int c;

        reset      = 1'b0;
        data_in    = '0;
        write_addr = '0;
        write_en   = 1'b0;
        start_cmd  = 1'b0;
        read_addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_done", 128'(done_flag), 128'd0);
        read_ct(ct);
        check_eq("reset_ct", ct, 128'd0);
        @(negedge clk);
        reset = 1'b1;

        // Known-answer vectors
        run_vec("fips_c3", KEY1, PT1, CT1);
        run_vec("sp800_f15", KEY2, PT2, CT2);
        run_vec("zero", 256'd0, 128'd0, CT0);
        for (int r = 0; r < 4; r++) begin
            read_addr = 2'(r);
            #1;
            check_eq($sformatf("zero_word%0d", r), 128'(data_out), 128'(CT0[127-32*r -: 32]));
        end

        // Back-to-back with writes while busy
        run_vec("b2b_first", KEY1, PT1, CT1);
        load_vector(KEY2, PT2);
        exp_q.push_back(CT2);
        start_pulse();
        check_eq("b2b_done_drop", 128'(done_flag), 128'd0);
        write_word(4'd0, 32'hdeadbeef);
        write_word(4'd8, 32'h12345678);
        read_ct(ct);
        check_eq("b2b_ct_hold", ct, CT1);
        wait_done(2, c);
        finish_vec("b2b_second", c);

        // Reset during round 7 aborts
        load_vector(KEY1, PT1);
        start_pulse();
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_eq("abort_done", 128'(done_flag), 128'd0);
        read_ct(ct);
        check_eq("abort_ct", ct, 128'd0);
        repeat (20) @(posedge clk);
        #1;
        check_eq("abort_no_late_done", 128'(done_flag), 128'd0);
        run_vec("after_abort", KEY2, PT2, CT2);

        // start with write_en is ignored in DONE
        @(negedge clk);
        write_en   = 1'b1;
        write_addr = 4'd12;
        data_in    = 32'hffffffff;
        start_cmd  = 1'b1;
        @(posedge clk);
        #1;
        write_en  = 1'b0;
        start_cmd = 1'b0;
        check_eq("start_with_wr_done", 128'(done_flag), 128'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("start_with_wr_hold", 128'(done_flag), 128'd1);
        read_ct(ct);
        check_eq("start_with_wr_ct", ct, CT2);

        // Start while busy does not restart
        load_vector(KEY1, PT1);
        exp_q.push_back(CT1);
        start_pulse();
        repeat (4) @(posedge clk);
        #1;
        start_pulse();
        wait_done(5, c);
        finish_vec("restart_ignored", c);

        check_eq("sb_drained", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
